tl_phase_sched: RTL and testbench

//  Timed phase scheduler for a two-road intersection with protected left turns.

---
 rtl/tl_phase_sched.sv | 179 +++++++++++++++++
 tb/tb_tl_phase_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_sched.sv
// rtl/tl_phase_sched.sv - timed four-phase intersection scheduler (optional pedestrian walk: TL_PED_EN)
module tl_phase_sched #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
`ifdef TL_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] phase
);

    localparam logic [2:0] S_G   = 3'd0;
    localparam logic [2:0] S_Y   = 3'd1;
    localparam logic [2:0] S_AR  = 3'd2;
`ifdef TL_PED_EN
    localparam logic [2:0] S_WK  = 3'd3;
    localparam logic [2:0] S_ARW = 3'd4;  // clearance after walk: always resumes the phase cycle
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_T - 1);
`endif

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_END   = CNT_W'(YELLOW_T - 1);
    localparam int CNT_NEED = ((GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T) - 1;

    // The timer must be able to reach every threshold it is compared against.
    if (CNT_NEED > (2 ** CNT_W) - 1) begin : g_cnt_check
        $error("CNT_W too narrow for GREEN_MAX/WALK_T");
    end

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_LEFT   = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       la_q, la_d;
    logic [1:0]       lb_q, lb_d;
    logic [3:0]       dem;
    logic             other;
    logic [1:0]       nxt;
    logic [1:0]       cand;
    logic             found;
    logic [1:0]       act_code;
`ifdef TL_PED_EN
    logic             ped_pend_q, ped_pend_d;
    logic             walk_q, walk_d;
`endif

    // Next-state, next-phase, timer and registered light codes.
    always_comb begin
        dem      = {Tbl, Tb, Tal, Ta};
        other    = |(dem & ~(4'b0001 << phase_q));
`ifdef TL_PED_EN
        other    = other | ped_pend_q;
`endif
        nxt      = 2'd0;
        found    = 1'b0;
        cand     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = phase_q + 2'(i);
            if (!found && dem[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end

        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_G: begin
                if (timer_q >= GMIN_M1 && other && (!dem[phase_q] || timer_q >= GMAX_M1))
                    state_d = S_Y;
            end
            S_Y: begin
                if (timer_q == Y_END)
                    state_d = S_AR;
            end
            S_AR: begin
`ifdef TL_PED_EN
                if (ped_pend_q) begin
                    state_d = S_WK;
                end else begin
                    state_d = S_G;
                    phase_d = nxt;
                end
`else
                state_d = S_G;
                phase_d = nxt;
`endif
            end
`ifdef TL_PED_EN
            S_WK: begin
                if (timer_q == WALK_END)
                    state_d = S_ARW;
            end
            S_ARW: begin
                state_d = S_G;
                phase_d = nxt;
            end
`endif
            default: begin
                state_d = S_G;
                phase_d = 2'd0;
            end
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (&timer_q)
            timer_d = timer_q;
        else
            timer_d = timer_q + 1'b1;

`ifdef TL_PED_EN
        // A request arriving on the walk-entry edge survives the clear.
        ped_pend_d = ped_req | (ped_pend_q & (state_d != S_WK || state_q == S_WK));
        walk_d     = (state_d == S_WK);
`endif

        act_code = phase_d[0] ? L_LEFT : L_GREEN;
        la_d     = L_RED;
        lb_d     = L_RED;
        if (state_d == S_G) begin
            if (phase_d[1]) lb_d = act_code;
            else            la_d = act_code;
        end else if (state_d == S_Y) begin
            if (phase_d[1]) lb_d = L_YELLOW;
            else            la_d = L_YELLOW;
        end
    end

    // State registers with synchronous reset to green on road A straight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_G;
            phase_q <= 2'd0;
            timer_q <= '0;
            la_q    <= L_GREEN;
            lb_q    <= L_RED;
`ifdef TL_PED_EN
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
`ifdef TL_PED_EN
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
`endif
        end
    end

    assign La    = la_q;
    assign Lb    = lb_q;
    assign phase = {1'b0, phase_q};
`ifdef TL_PED_EN
    assign walk  = walk_q;
`endif

endmodule

// File: tb/tb_tl_phase_sched.sv
// tb/tb_tl_phase_sched.sv - directed bench with behavioural intersection model for tl_phase_sched
module tb_tl_phase_sched;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 12;
    localparam int YELLOW_T  = 2;
    localparam int WALK_T    = 6;

    localparam int K_GREEN = 0;
    localparam int K_YEL   = 1;
    localparam int K_RED   = 2;
    localparam int K_WALK  = 3;
    localparam int K_RED_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
    logic [1:0] La, Lb;
    logic [2:0] phase;
`ifdef TL_PED_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    tl_phase_sched dut (
        .clk(clk), .reset(reset),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
`ifdef TL_PED_EN
        .ped_req(ped_req), .walk(walk),
`endif
        .La(La), .Lb(Lb), .phase(phase)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_kind, m_p, m_t, m_pend;

    logic [1:0] hla [0:63];
    logic [1:0] hlb [0:63];
    logic [2:0] hph [0:63];
    logic       hwk [0:63];
    int hn = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Intersection rules: how long each light has been shown, and who is served next.
    task automatic model_step();
        int d [4];
        int others, pend_next, seen;
        d[0] = int'(Ta); d[1] = int'(Tal); d[2] = int'(Tb); d[3] = int'(Tbl);
        pend_next = m_pend;
`ifdef TL_PED_EN
        if (ped_req) pend_next = 1;
`endif
        if (reset) begin
            m_kind = K_GREEN; m_p = 0; m_t = 0; m_pend = 0;
            return;
        end
        seen = m_t + 1;
        case (m_kind)
            K_GREEN: begin
                others = m_pend;
                for (int q = 0; q < 4; q++) if (q != m_p && d[q] != 0) others = 1;
                if (seen >= GREEN_MIN && others != 0 && (d[m_p] == 0 || seen >= GREEN_MAX)) begin
                    m_kind = K_YEL; m_t = 0;
                end else m_t++;
            end
            K_YEL: begin
                if (seen == YELLOW_T) begin m_kind = K_RED; m_t = 0; end
                else m_t++;
            end
            K_WALK: begin
                if (seen == WALK_T) begin m_kind = K_RED_W; m_t = 0; end
                else m_t++;
            end
            default: begin
                if (m_kind == K_RED && m_pend != 0) begin
                    m_kind = K_WALK;
                    pend_next = 0;
`ifdef TL_PED_EN
                    if (ped_req) pend_next = 1;
`endif
                end else begin
                    int sel;
                    sel = 0;
                    for (int k = 4; k >= 1; k--) if (d[(m_p + k) % 4] != 0) sel = (m_p + k) % 4;
                    m_kind = K_GREEN;
                    m_p = sel;
                end
                m_t = 0;
            end
        endcase
        m_pend = pend_next;
    endtask

    function automatic int exp_light(input int road);
        int on_road;
        on_road = ((m_p >= 2) ? 1 : 0) == road;
        if (m_kind == K_GREEN && on_road) return (m_p % 2 == 1) ? 2 : 0;
        if (m_kind == K_YEL && on_road) return 1;
        return 3;
    endfunction

    // One clock: advance the model on the edge, compare on the falling edge, record history.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("La", {6'd0, La}, 8'(exp_light(0)));
        chk("Lb", {6'd0, Lb}, 8'(exp_light(1)));
        chk("phase", {5'd0, phase}, 8'(m_p));
`ifdef TL_PED_EN
        chk("walk", {7'd0, walk}, 8'(m_kind == K_WALK));
`endif
        if (hn < 64) begin
            hla[hn] = La; hlb[hn] = Lb; hph[hn] = phase;
`ifdef TL_PED_EN
            hwk[hn] = walk;
`else
            hwk[hn] = 1'b0;
`endif
            hn++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // History index 0 is the observation right after the last reset edge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n - 1);
        hn = 0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        m_kind = K_GREEN; m_p = 0; m_t = 0; m_pend = 0;

        // Idle intersection rests on AG.
        do_reset(3);
        run(19);
        chk("t1_la0", {6'd0, hla[0]}, 8'd0);
        chk("t1_lb0", {6'd0, hlb[0]}, 8'd3);
        chk("t1_ph0", {5'd0, hph[0]}, 8'd0);
        chk("t1_la19", {6'd0, hla[19]}, 8'd0);
        chk("t1_ph19", {5'd0, hph[19]}, 8'd0);

        // Only B straight waiting: minimum green, yellow, all-red, BG.
        Tb = 1'b1;
        do_reset(3);
        run(7);
        chk("t2_la3", {6'd0, hla[3]}, 8'd0);
        chk("t2_la4", {6'd0, hla[4]}, 8'd1);
        chk("t2_la5", {6'd0, hla[5]}, 8'd1);
        chk("t2_ar_a", {6'd0, hla[6]}, 8'd3);
        chk("t2_ar_b", {6'd0, hlb[6]}, 8'd3);
        chk("t2_lb7", {6'd0, hlb[7]}, 8'd0);
        chk("t2_ph7", {5'd0, hph[7]}, 8'd2);

        // Both straights held: max green on each side.
        Ta = 1'b1; Tb = 1'b1;
        do_reset(3);
        run(30);
        chk("t3_la11", {6'd0, hla[11]}, 8'd0);
        chk("t3_la12", {6'd0, hla[12]}, 8'd1);
        chk("t3_ar", {6'd0, hlb[14]}, 8'd3);
        chk("t3_lb15", {6'd0, hlb[15]}, 8'd0);
        chk("t3_lb26", {6'd0, hlb[26]}, 8'd0);
        chk("t3_lb27", {6'd0, hlb[27]}, 8'd1);
        chk("t3_la30", {6'd0, hla[30]}, 8'd0);
        chk("t3_ph30", {5'd0, hph[30]}, 8'd0);

        // Only B left: AL and BG skipped.
        Ta = 1'b0; Tb = 1'b0; Tbl = 1'b1;
        do_reset(3);
        run(7);
        chk("t4_la6", {6'd0, hla[6]}, 8'd3);
        chk("t4_lb7", {6'd0, hlb[7]}, 8'd2);
        chk("t4_ph7", {5'd0, hph[7]}, 8'd3);

        // Demand disappears during yellow: fall back to AG.
        Tbl = 1'b0; Tb = 1'b1;
        do_reset(3);
        run(4);
        Tb = 1'b0;
        run(5);
        chk("t5_la6", {6'd0, hla[6]}, 8'd3);
        chk("t5_la7", {6'd0, hla[7]}, 8'd0);
        chk("t5_ph7", {5'd0, hph[7]}, 8'd0);
        chk("t5_la9", {6'd0, hla[9]}, 8'd0);

        // Reset during the second yellow cycle aborts it and restarts the timer.
        Tb = 1'b1;
        do_reset(3);
        run(5);
        chk("t6_la5", {6'd0, hla[5]}, 8'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(4);
        chk("t6_la6", {6'd0, hla[6]}, 8'd0);
        chk("t6_lb6", {6'd0, hlb[6]}, 8'd3);
        chk("t6_ph6", {5'd0, hph[6]}, 8'd0);
        chk("t6_la9", {6'd0, hla[9]}, 8'd0);
        chk("t6_la10", {6'd0, hla[10]}, 8'd1);

`ifdef TL_PED_EN
        // Pedestrian pulse with no vehicle demand.
        Tb = 1'b0;
        do_reset(3);
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        run(15);
        chk("t7_la3", {6'd0, hla[3]}, 8'd0);
        chk("t7_la4", {6'd0, hla[4]}, 8'd1);
        chk("t7_ar", {6'd0, hla[6]}, 8'd3);
        chk("t7_wk7", {7'd0, hwk[7]}, 8'd1);
        chk("t7_wk12", {7'd0, hwk[12]}, 8'd1);
        chk("t7_wk13", {7'd0, hwk[13]}, 8'd0);
        chk("t7_la13", {6'd0, hla[13]}, 8'd3);
        chk("t7_la14", {6'd0, hla[14]}, 8'd0);
        chk("t7_la16", {6'd0, hla[16]}, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
